riscv_mdu: RTL
==============

# riscv_mdu

Parametrised, iterative multiply/divide unit implementing the RISC-V M-extension operations alongside the single-cycle integer ALU in the CPU execute stage. Operands enter through a valid/ready handshake, are processed one bit per cycle by a shared shift-add/shift-subtract datapath, and leave through a second valid/ready handshake. Results are held until consumed. Divide-by-zero and signed-overflow cases are resolved on a fast path.

## Interface
- XLEN, 32: operand/result width; legal values are 8, 16, 32, 64.
- CNT_W, $clog2(XLEN)+1: iteration counter width; derived, not overridden.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort; drops any operation in flight
- in_valid  in  1  operands and op are valid
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- out_valid  out  1  result is valid
- out_ready  in  1  consumer takes result
- result  out  XLEN  operation result
- busy  out  1  state != IDLE

## Operation
- The unit has four states:
  - IDLE: in_ready=1. On in_valid, latch op, a and b, and take absolute values where op is signed.
    - DIV/REM with b==0: go to DONE. Quotient is all-ones; remainder is a.
    - DIV/REM with a==MIN_INT and b==all-ones: go to DONE. Quotient is MIN_INT; remainder is 0.
    - Otherwise go to CALC with the counter set to XLEN.
  - CALC: perform one radix-2 iteration per cycle and decrement the counter. When the counter reaches 1, go to FIX.
  - FIX: apply sign correction and select the high or low product, or the quotient or remainder. Go to DONE.
  - DONE: out_valid=1. Go to IDLE on out_ready.
- Signedness rules:
  - MULH: signed × signed.
  - MULHSU: signed a × unsigned b.
  - Quotient sign is sign(a) XOR sign(b).
  - Remainder sign is sign(a).
- The multiplier keeps a 2·XLEN product register. MUL returns the low half; the MULH variants return the high half.
- result and out_valid change only on the FIX→DONE or fast-path→DONE transition. They are held stable while out_valid is high and out_ready is low.
- flush has priority over every transition: the next state is IDLE and out_valid drops. The latched result value is don't-care after a flush.
- op, a and b are ignored while in_ready is low.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, state IDLE.
- Reset asserted mid-operation forces IDLE asynchronously. No result is produced.
- Accept edge is E0 (in_valid & in_ready).
  - Normal path: out_valid rises after edge E0+XLEN+1, i.e. XLEN+2 cycles from the accept cycle to the first result cycle.
  - Fast path: out_valid rises after E1.
- Handshake: the result transfers on the edge where out_valid & out_ready. in_ready rises after that edge. There is no back-to-back accept in the same cycle as the output transfer, so throughput is one operation per XLEN+3 cycles.
- flush and in_valid in the same IDLE cycle: flush wins and nothing is accepted.

## Structure
- Package riscv_mdu_pkg holds:
  - the op encodings as localparams MDU_MUL … MDU_REMU;
  - the state enum (IDLE, CALC, FIX, DONE);
  - helper functions is_div(op) and is_signed_a(op) / is_signed_b(op).
- Sub-module riscv_mdu_step is combinational. It covers one multiply add-shift or one restoring-divide subtract-shift step, selected by a mode bit. It is instantiated once.
- The top level contains the FSM, counter, operand and product registers, and output register.

## Test plan
- MUL, a=7, b=6 (XLEN=32) → result 0x0000002A. out_valid is first seen 34 cycles after the accept cycle.
- a=0xFFFFFFFF, b=4:
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000003.
  - MULHSU → 0xFFFFFFFF.
  - MUL → 0xFFFFFFFC.
- a=0xFFFFFFF9, b=2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
  - REMU → 0x00000001.
- Fast path:
  - DIV a=5, b=0 → 0xFFFFFFFF.
  - REMU a=5, b=0 → 0x00000005.
  - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - Each has out_valid after E1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. result and out_valid stay stable and in_ready stays 0. in_ready=1 the cycle after the out_ready=1 transfer.
- Aborts:
  - flush asserted at iteration 10 of a DIV → out_valid stays 0 and in_ready=1 next cycle. A following MUL a=3, b=4 → 0x0000000C.
  - Repeat the abort with rst_n pulsed low.
  - Rerun the MUL/DIV cases with XLEN=16.

Source files
------------

// File: rtl/riscv_mdu_pkg.sv
// riscv_mdu_pkg: op encodings, FSM state codes and op-decode helpers shared by the MDU files
package riscv_mdu_pkg;
   localparam logic [2:0] MDU_MUL    = 3'd0;
   localparam logic [2:0] MDU_MULH   = 3'd1;
   localparam logic [2:0] MDU_MULHSU = 3'd2;
   localparam logic [2:0] MDU_MULHU  = 3'd3;
   localparam logic [2:0] MDU_DIV    = 3'd4;
   localparam logic [2:0] MDU_DIVU   = 3'd5;
   localparam logic [2:0] MDU_REM    = 3'd6;
   localparam logic [2:0] MDU_REMU   = 3'd7;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction
   function automatic logic is_signed_a(input logic [2:0] op);
      return op == MDU_MULH || op == MDU_MULHSU || op == MDU_DIV || op == MDU_REM;
   endfunction
   function automatic logic is_signed_b(input logic [2:0] op);
      return op == MDU_MULH || op == MDU_DIV || op == MDU_REM;
   endfunction
endpackage

// File: rtl/riscv_mdu_if.sv
// riscv_mdu_if: MDU request/response bundle (flush, in_valid/in_ready/op/a/b, out_valid/out_ready/result, busy)
interface riscv_mdu_if #(parameter int XLEN = 32);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;
   modport master (output flush, in_valid, op, a, b, out_ready, input in_ready, out_valid, result, busy);
   modport slave  (input flush, in_valid, op, a, b, out_ready, output in_ready, out_valid, result, busy);
endinterface

// File: rtl/riscv_mdu_step.sv
// riscv_mdu_step: one radix-2 step; i_div=0 add-shift multiply, i_div=1 restoring subtract-shift divide
// Ports: i_p product/remainder:quotient register in, i_m multiplicand/divisor, o_p register after one step
module riscv_mdu_step #(parameter int XLEN = 32) (
   input  logic              i_div,
   input  logic [2*XLEN-1:0] i_p,
   input  logic [XLEN-1:0]   i_m,
   output logic [2*XLEN-1:0] o_p
);
   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_rem;
   logic            w_ge;
   logic [XLEN-1:0] w_diff;
   always_comb begin
      w_sum  = {1'b0, i_p[2*XLEN-1:XLEN]} + (i_p[0] ? {1'b0, i_m} : '0);
      w_rem  = {i_p[2*XLEN-1:XLEN], i_p[XLEN-1]};
      w_ge   = w_rem >= {1'b0, i_m};
      // the shifted remainder is below twice the divisor, so the difference fits XLEN bits
      w_diff = w_rem[XLEN-1:0] - i_m;
      o_p    = i_div ? {w_ge ? w_diff : w_rem[XLEN-1:0], i_p[XLEN-2:0], w_ge} : {w_sum, i_p[XLEN-1:1]};
   end
endmodule

// File: rtl/riscv_mdu.sv
// riscv_mdu: iterative RISC-V M-extension multiply/divide unit, one bit per cycle
// Ports: clk, rst_n (async active-low); mdu slave modport with flush, input and output valid/ready handshakes, busy
module riscv_mdu import riscv_mdu_pkg::*; #(
   parameter  int XLEN  = 32,
   localparam int CNT_W = $clog2(XLEN) + 1
) (
   input  logic       clk,
   input  logic       rst_n,
   riscv_mdu_if.slave mdu
);
   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_op;
   logic              r_fast;
   logic              r_neg;
   logic [XLEN-1:0]   r_m;
   logic [2*XLEN-1:0] r_p;
   logic [XLEN-1:0]   r_res;
   logic              w_sa, w_sb, w_div0, w_ovf, w_fast;
   logic [XLEN-1:0]   w_abs_a, w_abs_b, w_fast_res, w_sel, w_fix;
   logic [2*XLEN-1:0] w_step_p, w_prod_n;
   assign w_sa       = is_signed_a(mdu.op) & mdu.a[XLEN-1];
   assign w_sb       = is_signed_b(mdu.op) & mdu.b[XLEN-1];
   assign w_abs_a    = w_sa ? -mdu.a : mdu.a;
   assign w_abs_b    = w_sb ? -mdu.b : mdu.b;
   assign w_div0     = is_div(mdu.op) & (mdu.b == '0);
   assign w_ovf      = is_div(mdu.op) & is_signed_b(mdu.op) & (mdu.a == {1'b1, {(XLEN-1){1'b0}}}) & (&mdu.b);
   assign w_fast     = w_div0 | w_ovf;
   // op[1] separates remainder from quotient among the divide ops
   assign w_fast_res = w_div0 ? (mdu.op[1] ? mdu.a : '1) : (mdu.op[1] ? '0 : mdu.a);
   // negating the full product keeps both halves correct for signed products
   assign w_prod_n   = r_neg ? -r_p : r_p;
   assign w_sel      = r_op[1] ? r_p[2*XLEN-1:XLEN] : r_p[XLEN-1:0];
   assign w_fix      = r_fast ? r_p[XLEN-1:0] :
                       is_div(r_op) ? (r_neg ? -w_sel : w_sel) :
                       (r_op == MDU_MUL ? w_prod_n[XLEN-1:0] : w_prod_n[2*XLEN-1:XLEN]);
   riscv_mdu_step #(.XLEN(XLEN)) u_step (.i_div(is_div(r_op)), .i_p(r_p), .i_m(r_m), .o_p(w_step_p));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_fast  <= 1'b0;
         r_neg   <= 1'b0;
         r_m     <= '0;
         r_p     <= '0;
         r_res   <= '0;
      end else if (mdu.flush) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (mdu.in_valid) begin
               r_op    <= mdu.op;
               r_fast  <= w_fast;
               r_neg   <= (is_div(mdu.op) & mdu.op[1]) ? w_sa : w_sa ^ w_sb;
               r_m     <= is_div(mdu.op) ? w_abs_b : w_abs_a;
               r_p     <= {{XLEN{1'b0}}, w_fast ? w_fast_res : (is_div(mdu.op) ? w_abs_a : w_abs_b)};
               r_cnt   <= CNT_W'(XLEN);
               r_state <= w_fast ? S_FIX : S_CALC;
            end
            S_CALC: begin
               r_p     <= w_step_p;
               r_cnt   <= r_cnt - 1'b1;
               r_state <= (r_cnt == CNT_W'(1)) ? S_FIX : S_CALC;
            end
            S_FIX: begin
               r_res   <= w_fix;
               r_state <= S_DONE;
            end
            default: r_state <= mdu.out_ready ? S_IDLE : S_DONE;
         endcase
      end
   end
   assign mdu.in_ready  = r_state == S_IDLE;
   assign mdu.busy      = r_state != S_IDLE;
   assign mdu.out_valid = r_state == S_DONE;
   assign mdu.result    = r_res;
endmodule
